pb_keypad_scanner: RTL and testbench

//  Input stage of the Simon Says datapath, sitting between the raw board push-buttons (pb[19:0])
//  and the simonsays game core.
//  - Synchronises the buttons, debounces them and rejects multi-key chords.
//  - Delivers exactly one encoded keypress per physical press over a valid/ready handshake.
//  - Reports dropped presses so the game core never misses or double-counts a player input.

---
 rtl/pb_keypad_scanner.sv | 163 ++++++++++++++++
 tb/tb_pb_keypad_scanner.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pb_keypad_scanner.sv
// Push-button front end for the Simon Says core: synchronises and debounces the
// buttons, rejects chords and hands exactly one encoded key per press to the consumer.
module pb_keypad_scanner #(
  parameter int NKEYS    = 20,
  parameter int CODEW    = 5,
  parameter int DEBOUNCE = 2
) (
  input  logic             hz100,
  input  logic             reset,
  input  logic [NKEYS-1:0] pb,
  input  logic             key_ready,
  input  logic             ovf_clr,
  output logic             key_valid,
  output logic [CODEW-1:0] key_code,
  output logic             key_held,
  output logic             multi,
  output logic             ovf
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEB  = 2'd1,
    ST_WREL = 2'd2
  } state_t;

  localparam logic [3:0]       DEB_FULL = 4'(DEBOUNCE);
  localparam logic [3:0]       DEB_LAST = 4'(DEBOUNCE - 1);
  localparam logic [NKEYS-1:0] ONE_V    = {{(NKEYS-1){1'b0}}, 1'b1};
  localparam logic [NKEYS-1:0] ZERO_V   = {NKEYS{1'b0}};

  // True when more than one bit of the vector is set.
  function automatic logic many_bits(input logic [NKEYS-1:0] v);
    return (v & (v - ONE_V)) != ZERO_V;
  endfunction

  // Binary index of the lowest set bit (zero when no bit is set).
  function automatic logic [CODEW-1:0] key_index(input logic [NKEYS-1:0] v);
    logic [CODEW-1:0] idx;
    idx = {CODEW{1'b0}};
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = CODEW'(i);
      end
    end
    return idx;
  endfunction

  state_t           state_r;
  logic [NKEYS-1:0] sync1_r;
  logic [NKEYS-1:0] sync2_r;
  logic [3:0]       cnt_r;
  logic [CODEW-1:0] cand_r;

  logic             s_zero_s;
  logic             s_many_s;
  logic             s_cand_s;
  logic [CODEW-1:0] s_idx_s;
  logic             accept_s;
  logic             xfer_s;
  logic             load_s;

  // Classify the synchronised vector and derive the accept/transfer strobes.
  always_comb begin
    s_zero_s = (sync2_r == ZERO_V);
    s_many_s = many_bits(sync2_r);
    s_idx_s  = key_index(sync2_r);
    s_cand_s = !s_zero_s && !s_many_s && (s_idx_s == cand_r);
    accept_s = (state_r == ST_DEB) && s_cand_s && (cnt_r == DEB_FULL);
    xfer_s   = key_valid && key_ready;
    // A press can be loaded if the slot is empty or being emptied this edge.
    load_s   = accept_s && (!key_valid || key_ready);
  end

  // Synchroniser, scan FSM and handshake/status output registers.
  always_ff @(posedge hz100) begin
    if (!reset) begin
      sync1_r   <= ZERO_V;
      sync2_r   <= ZERO_V;
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      cand_r    <= {CODEW{1'b0}};
      key_valid <= 1'b0;
      key_code  <= {CODEW{1'b0}};
      key_held  <= 1'b0;
      multi     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      sync1_r <= pb;
      sync2_r <= sync1_r;
      multi   <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          if (s_zero_s) begin
            cnt_r <= 4'd0;
          end else if (s_many_s) begin
            multi   <= 1'b1;
            cnt_r   <= 4'd0;
            state_r <= ST_WREL;
          end else begin
            cand_r  <= s_idx_s;
            cnt_r   <= 4'd1;
            state_r <= ST_DEB;
          end
        end
        ST_DEB: begin
          if (s_cand_s) begin
            if (cnt_r == DEB_FULL) begin
              key_held <= 1'b1;
              cnt_r    <= 4'd0;
              state_r  <= ST_WREL;
            end else begin
              cnt_r <= cnt_r + 4'd1;
            end
          end else if (s_zero_s) begin
            cnt_r   <= 4'd0;
            state_r <= ST_IDLE;
          end else begin
            // Another key joined or replaced the candidate: only chords pulse multi.
            multi   <= s_many_s;
            cnt_r   <= 4'd0;
            state_r <= ST_WREL;
          end
        end
        ST_WREL: begin
          if (!s_zero_s) begin
            cnt_r <= 4'd0;
          end else if (cnt_r == DEB_LAST) begin
            cnt_r    <= 4'd0;
            key_held <= 1'b0;
            state_r  <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        default: begin
          cnt_r    <= 4'd0;
          key_held <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase

      if (load_s) begin
        key_code  <= cand_r;
        key_valid <= 1'b1;
      end else if (xfer_s) begin
        key_valid <= 1'b0;
      end else begin
        key_valid <= key_valid;
      end

      // Set has priority over clear.
      if (accept_s && !load_s) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end else begin
        ovf <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_pb_keypad_scanner.sv
// Bench for pb_keypad_scanner: directed scenarios with literal expectations plus
// randomised button traffic checked every cycle against a run-length based model.
module tb_pb_keypad_scanner;

  localparam int NK  = 20;
  localparam int CW  = 5;
  localparam int DEB = 2;

  logic          hz100 = 1'b0;
  logic          reset;
  logic [NK-1:0] pb;
  logic          key_ready;
  logic          ovf_clr;
  logic          key_valid;
  logic [CW-1:0] key_code;
  logic          key_held;
  logic          multi;
  logic          ovf;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  pb_keypad_scanner #(.NKEYS(NK), .CODEW(CW), .DEBOUNCE(DEB)) dut (
    .hz100     (hz100),
    .reset     (reset),
    .pb        (pb),
    .key_ready (key_ready),
    .ovf_clr   (ovf_clr),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held),
    .multi     (multi),
    .ovf       (ovf)
  );

  initial forever #5 hz100 = ~hz100;

  // Model state: pb delay line, sample run lengths, armed flag and a one-entry key slot.
  logic [NK-1:0] d1, d2, prev_s;
  int  run_len, zero_run;
  bit  armed, m_held, m_multi, m_ovf;
  int  slot[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int low_index(input logic [NK-1:0] v);
    for (int i = 0; i < NK; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  function automatic logic [NK-1:0] key_bit(input int i);
    logic [NK-1:0] v;
    v = {NK{1'b0}};
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_step();
    logic [NK-1:0] s;
    bit acc;
    if (!reset) begin
      d1 = {NK{1'b0}}; d2 = {NK{1'b0}}; prev_s = {NK{1'b0}};
      run_len = 0; zero_run = 0;
      armed = 1'b1; m_held = 1'b0; m_multi = 1'b0; m_ovf = 1'b0;
      slot.delete();
    end else begin
      s  = d2;
      d2 = d1;
      d1 = pb;
      run_len  = (s == prev_s) ? run_len + 1 : 1;
      zero_run = (s == {NK{1'b0}}) ? zero_run + 1 : 0;
      m_multi = 1'b0;
      acc = 1'b0;
      if (armed) begin
        if (s != {NK{1'b0}}) begin
          if ((prev_s != {NK{1'b0}} && s != prev_s) || $countones(s) > 1) begin
            armed   = 1'b0;
            m_multi = ($countones(s) > 1);
          end else if (run_len == DEB + 1) begin
            armed  = 1'b0;
            m_held = 1'b1;
            acc    = 1'b1;
          end
        end
      end else if (zero_run == DEB) begin
        armed  = 1'b1;
        m_held = 1'b0;
      end
      prev_s = s;
      if (slot.size() > 0 && key_ready) void'(slot.pop_front());
      if (acc && slot.size() != 0) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      if (acc && slot.size() == 0) slot.push_back(low_index(s));
    end
  endtask

  // Advance the model on each edge and compare the DUT outputs just after it.
  initial begin
    forever begin
      @(posedge hz100);
      model_step();
      #1;
      if (model_on) begin
        chk("key_valid", int'(key_valid), int'(slot.size() > 0));
        if (slot.size() > 0) chk("key_code", int'(key_code), slot[0]);
        chk("key_held", int'(key_held), int'(m_held));
        chk("multi", int'(multi), int'(m_multi));
        chk("ovf", int'(ovf), int'(m_ovf));
      end
    end
  end

  task automatic tick();
    @(posedge hz100);
    #2;
  endtask

  int r_kind, r_len, r_a, r_b;

  initial begin
    pb = {NK{1'b0}}; reset = 1'b0; key_ready = 1'b0; ovf_clr = 1'b0;

    // Reset held for two edges with a button down.
    pb = 20'h00010;
    tick(); tick();
    chk("rst_valid", int'(key_valid), 0);
    chk("rst_code", int'(key_code), 0);
    chk("rst_held", int'(key_held), 0);
    chk("rst_multi", int'(multi), 0);
    chk("rst_ovf", int'(ovf), 0);
    reset = 1'b1; pb = {NK{1'b0}}; model_on = 1'b1;
    repeat (4) tick();
    chk("rst_nokey", int'(key_valid), 0);

    // Single press of key 7 with consumer ready.
    key_ready = 1'b1; pb = key_bit(7);
    tick(); tick(); tick(); tick();
    chk("t2_early", int'(key_valid), 0);
    tick();
    chk("t2_valid", int'(key_valid), 1);
    chk("t2_code", int'(key_code), 7);
    chk("t2_held", int'(key_held), 1);
    tick();
    chk("t2_xfer", int'(key_valid), 0);
    pb = {NK{1'b0}};
    tick(); tick(); tick();
    chk("t2_held_rel", int'(key_held), 1);
    tick();
    chk("t2_held_off", int'(key_held), 0);

    // One-cycle glitch on key 3.
    pb = key_bit(3); tick(); pb = {NK{1'b0}};
    repeat (8) tick();
    chk("t3_valid", int'(key_valid), 0);
    chk("t3_ovf", int'(ovf), 0);
    chk("t3_held", int'(key_held), 0);

    // Chord of keys 2 and 5, then key 5 alone.
    pb = key_bit(2) | key_bit(5);
    tick(); tick();
    chk("t4_multi_early", int'(multi), 0);
    tick();
    chk("t4_multi", int'(multi), 1);
    tick();
    chk("t4_multi_pulse", int'(multi), 0);
    chk("t4_valid", int'(key_valid), 0);
    repeat (3) tick();
    pb = {NK{1'b0}};
    repeat (6) tick();
    pb = key_bit(5);
    repeat (5) tick();
    chk("t4_valid5", int'(key_valid), 1);
    chk("t4_code5", int'(key_code), 5);
    pb = {NK{1'b0}};
    repeat (8) tick();

    // Overflow: key 4 pending while key 9 is accepted.
    key_ready = 1'b0;
    pb = key_bit(4); repeat (6) tick(); pb = {NK{1'b0}}; repeat (6) tick();
    pb = key_bit(9); repeat (6) tick(); pb = {NK{1'b0}}; repeat (6) tick();
    chk("t5_code", int'(key_code), 4);
    chk("t5_valid", int'(key_valid), 1);
    chk("t5_ovf", int'(ovf), 1);
    key_ready = 1'b1; tick();
    chk("t5_xfer", int'(key_valid), 0);
    chk("t5_ovf_sticky", int'(ovf), 1);
    key_ready = 1'b0; ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("t5_ovf_clr", int'(ovf), 0);

    // Key 12 accepted on the very edge key 1 transfers.
    pb = key_bit(1); repeat (6) tick(); pb = {NK{1'b0}}; repeat (6) tick();
    chk("t6_pending", int'(key_code), 1);
    pb = key_bit(12);
    repeat (4) tick();
    key_ready = 1'b1;
    tick();
    chk("t6_valid", int'(key_valid), 1);
    chk("t6_code", int'(key_code), 12);
    chk("t6_ovf", int'(ovf), 0);
    key_ready = 1'b0;
    repeat (2) tick(); pb = {NK{1'b0}}; repeat (6) tick();
    key_ready = 1'b1; tick(); key_ready = 1'b0;

    // Randomised traffic including occasional mid-operation resets.
    for (int n = 0; n < 500; n++) begin
      r_kind = $urandom_range(0, 9);
      r_a = $urandom_range(0, NK - 1);
      r_b = $urandom_range(0, NK - 1);
      if (r_kind < 3) pb = {NK{1'b0}};
      else if (r_kind < 8) pb = key_bit(r_a);
      else if (r_kind == 8) pb = key_bit(r_a) | key_bit(r_b);
      else pb = NK'($urandom);
      r_len = $urandom_range(1, 10);
      for (int c = 0; c < r_len; c++) begin
        key_ready = ($urandom_range(0, 1) == 1);
        ovf_clr   = ($urandom_range(0, 15) == 0);
        reset     = ($urandom_range(0, 299) != 0);
        tick();
      end
    end

    reset = 1'b1; pb = {NK{1'b0}}; key_ready = 1'b1; ovf_clr = 1'b0;
    repeat (10) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
